// File: rtl/sale_terminal_pkg.sv
// Shared encodings for the sale terminal: command opcodes, error codes and the
// basket sequencer FSM states.
package sale_terminal_pkg;

  localparam int unsigned MaxQtyDefault = 9;

  typedef enum logic [1:0] {
    OpAdd    = 2'd0,
    OpRemove = 2'd1,
    OpClear  = 2'd2,
    OpRsvd   = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ErrNone     = 3'd0,
    ErrFull     = 3'd1,
    ErrNotFound = 3'd2,
    ErrZeroQty  = 3'd3,
    ErrQtySat   = 3'd4,
    ErrBadOp    = 3'd5
  } err_code_e;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWait,
    StCommit,
    StClear
  } state_e;

endpackage

// File: rtl/basket_entry_file.sv
// Basket entry table: valid/ID/qty per slot, parallel ID match, lowest-free-slot
// select and a combinational display read port.
module basket_entry_file #(
  parameter int unsigned MaxItems = 8,
  parameter int unsigned IdW      = 4,
  parameter int unsigned QtyW     = 4,
  parameter int unsigned IdxW     = $clog2(MaxItems)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            wr_en_i,
  input  logic [IdxW-1:0] wr_idx_i,
  input  logic [IdW-1:0]  wr_id_i,
  input  logic [QtyW-1:0] wr_qty_i,
  input  logic            inv_en_i,
  input  logic [IdxW-1:0] inv_idx_i,
  input  logic [IdW-1:0]  match_id_i,
  output logic            hit_o,
  output logic [IdxW-1:0] hit_idx_o,
  output logic [QtyW-1:0] hit_qty_o,
  output logic            free_ok_o,
  output logic [IdxW-1:0] free_idx_o,
  input  logic [IdxW-1:0] rd_idx_i,
  output logic            rd_valid_o,
  output logic [IdW-1:0]  rd_id_o,
  output logic [QtyW-1:0] rd_qty_o
);

  logic            valid_q [MaxItems];
  logic [IdW-1:0]  id_q    [MaxItems];
  logic [QtyW-1:0] qty_q   [MaxItems];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < MaxItems; i++) begin
        valid_q[i] <= 1'b0;
        id_q[i]    <= '0;
        qty_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < MaxItems; i++) begin
        if (clr_i) begin
          valid_q[i] <= 1'b0;
        end else if (wr_en_i && wr_idx_i == IdxW'(i)) begin
          valid_q[i] <= 1'b1;
          id_q[i]    <= wr_id_i;
          qty_q[i]   <= wr_qty_i;
        end else if (inv_en_i && inv_idx_i == IdxW'(i)) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  // IDs are unique among valid entries, so the first hit is the only hit.
  always_comb begin
    hit_o     = 1'b0;
    hit_idx_o = '0;
    hit_qty_o = '0;
    for (int unsigned i = 0; i < MaxItems; i++) begin
      if (!hit_o && valid_q[i] && id_q[i] == match_id_i) begin
        hit_o     = 1'b1;
        hit_idx_o = IdxW'(i);
        hit_qty_o = qty_q[i];
      end
    end
  end

  // Scan downwards so the lowest invalid slot wins.
  always_comb begin
    free_ok_o  = 1'b0;
    free_idx_o = '0;
    for (int i = int'(MaxItems) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_ok_o  = 1'b1;
        free_idx_o = IdxW'(i);
      end
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_id_o    = id_q[rd_idx_i];
  assign rd_qty_o   = qty_q[rd_idx_i];

endmodule

// File: rtl/basket_sequencer.sv
// Basket command sequencer: latches ADD/REMOVE/CLEAR commands, performs one price
// ROM lookup per command and commits entry, count and running-total updates.
module basket_sequencer
  import sale_terminal_pkg::*;
#(
  parameter int unsigned MAX_ITEMS = 8,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned QTY_W     = 4,
  parameter int unsigned MAX_QTY   = MaxQtyDefault,
  parameter int unsigned PRICE_W   = 8,
  parameter int unsigned TOTAL_W   = 16
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic               CMD_Valid,
  input  logic [1:0]         CMD_Op,
  input  logic [ID_W-1:0]    CMD_ID,
  input  logic [QTY_W-1:0]   CMD_Qty,
  output logic               CMD_Ready,
  output logic               CMD_Done,
  output logic               CMD_Err,
  output logic [2:0]         Err_Code,
  output logic [ID_W-1:0]    Price_Addr,
  input  logic [PRICE_W-1:0] Price_Data,
  output logic [3:0]         BasketProductNum,
  output logic [TOTAL_W-1:0] Total,
  input  logic [2:0]         Rd_Index,
  output logic               Rd_Valid,
  output logic [ID_W-1:0]    Rd_ID,
  output logic [QTY_W-1:0]   Rd_Qty
);

  localparam int unsigned IdxW  = $clog2(MAX_ITEMS);
  localparam int unsigned ProdW = QTY_W + PRICE_W;

  state_e               state_q, state_d;
  cmd_op_e              op_q;
  logic [ID_W-1:0]      id_q, addr_q;
  logic [QTY_W-1:0]     qty_q, hit_qty_q;
  logic                 hit_q, free_ok_q;
  logic [IdxW-1:0]      hit_idx_q, free_idx_q;
  logic [PRICE_W-1:0]   price_q;
  logic [TOTAL_W-1:0]   total_q, total_d;
  logic [3:0]           count_q, count_d;

  logic                 hit, free_ok;
  logic [IdxW-1:0]      hit_idx, free_idx;
  logic [QTY_W-1:0]     hit_qty;

  logic                 wr_en, inv_en, clr;
  logic [IdxW-1:0]      wr_idx;
  logic [QTY_W-1:0]     wr_qty, dq;
  logic                 acc_add, acc_sub, err;
  err_code_e            err_code;
  logic [ProdW-1:0]     prod;

  // Saturating-add operands are evaluated one bit wider so the sum cannot wrap.
  logic [QTY_W:0]       sum;
  logic                 sum_sat, qty_sat;
  assign sum     = {1'b0, hit_qty_q} + {1'b0, qty_q};
  assign sum_sat = sum > (QTY_W + 1)'(MAX_QTY);
  assign qty_sat = qty_q > QTY_W'(MAX_QTY);

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (CMD_Valid) begin
          unique case (cmd_op_e'(CMD_Op))
            OpAdd, OpRemove: state_d = StLookup;
            OpClear:         state_d = StClear;
            OpRsvd:          state_d = StCommit;
          endcase
        end
      end
      StLookup: state_d = StWait;
      StWait:   state_d = StCommit;
      StCommit: state_d = StIdle;
      StClear:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    CMD_Ready = (state_q == StIdle);
    CMD_Done  = (state_q == StCommit) || (state_q == StClear);
    CMD_Err   = (state_q == StCommit) && err;
    Err_Code  = CMD_Err ? err_code : ErrNone;
  end

  always_comb begin
    wr_en    = 1'b0;
    inv_en   = 1'b0;
    clr      = (state_q == StClear);
    wr_idx   = hit_idx_q;
    wr_qty   = '0;
    dq       = '0;
    acc_add  = 1'b0;
    acc_sub  = 1'b0;
    err      = 1'b0;
    err_code = ErrNone;
    count_d  = count_q;
    if (state_q == StCommit) begin
      unique case (op_q)
        OpAdd: begin
          if (qty_q == '0) begin
            err      = 1'b1;
            err_code = ErrZeroQty;
          end else if (hit_q) begin
            wr_en   = 1'b1;
            wr_qty  = sum_sat ? QTY_W'(MAX_QTY) : sum[QTY_W-1:0];
            dq      = wr_qty - hit_qty_q;
            acc_add = 1'b1;
            if (sum_sat) begin
              err      = 1'b1;
              err_code = ErrQtySat;
            end
          end else if (!free_ok_q) begin
            err      = 1'b1;
            err_code = ErrFull;
          end else begin
            wr_en   = 1'b1;
            wr_idx  = free_idx_q;
            wr_qty  = qty_sat ? QTY_W'(MAX_QTY) : qty_q;
            dq      = wr_qty;
            acc_add = 1'b1;
            count_d = count_q + 4'd1;
            if (qty_sat) begin
              err      = 1'b1;
              err_code = ErrQtySat;
            end
          end
        end
        OpRemove: begin
          if (hit_q) begin
            inv_en  = 1'b1;
            dq      = hit_qty_q;
            acc_sub = 1'b1;
            count_d = count_q - 4'd1;
          end else begin
            err      = 1'b1;
            err_code = ErrNotFound;
          end
        end
        OpClear, OpRsvd: begin
          err      = 1'b1;
          err_code = ErrBadOp;
        end
      endcase
    end
    prod = ProdW'(dq) * ProdW'(price_q);
    if (clr) begin
      total_d = '0;
      count_d = '0;
    end else if (acc_add) begin
      total_d = total_q + TOTAL_W'(prod);
    end else if (acc_sub) begin
      total_d = total_q - TOTAL_W'(prod);
    end else begin
      total_d = total_q;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      op_q       <= OpAdd;
      id_q       <= '0;
      qty_q      <= '0;
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
      hit_qty_q  <= '0;
      free_ok_q  <= 1'b0;
      free_idx_q <= '0;
      price_q    <= '0;
      addr_q     <= '0;
      total_q    <= '0;
      count_q    <= '0;
    end else begin
      if (state_q == StIdle && CMD_Valid) begin
        op_q  <= cmd_op_e'(CMD_Op);
        id_q  <= CMD_ID;
        qty_q <= CMD_Qty;
      end
      if (state_q == StLookup) begin
        addr_q     <= id_q;
        hit_q      <= hit;
        hit_idx_q  <= hit_idx;
        hit_qty_q  <= hit_qty;
        free_ok_q  <= free_ok;
        free_idx_q <= free_idx;
      end
      if (state_q == StWait) price_q <= Price_Data;
      total_q <= total_d;
      count_q <= count_d;
    end
  end

  assign Price_Addr       = addr_q;
  assign Total            = total_q;
  assign BasketProductNum = count_q;

  basket_entry_file #(
    .MaxItems (MAX_ITEMS),
    .IdW      (ID_W),
    .QtyW     (QTY_W),
    .IdxW     (IdxW)
  ) u_entries (
    .clk_i      (CLOCK_50),
    .rst_i      (RESET),
    .clr_i      (clr),
    .wr_en_i    (wr_en),
    .wr_idx_i   (wr_idx),
    .wr_id_i    (id_q),
    .wr_qty_i   (wr_qty),
    .inv_en_i   (inv_en),
    .inv_idx_i  (hit_idx_q),
    .match_id_i (id_q),
    .hit_o      (hit),
    .hit_idx_o  (hit_idx),
    .hit_qty_o  (hit_qty),
    .free_ok_o  (free_ok),
    .free_idx_o (free_idx),
    .rd_idx_i   (Rd_Index),
    .rd_valid_o (Rd_Valid),
    .rd_id_o    (Rd_ID),
    .rd_qty_o   (Rd_Qty)
  );

endmodule

// File: tb/tb_basket_sequencer.sv
// Directed self-checking bench for basket_sequencer; price ROM modelled as
// price = 10 + 5*id, read combinationally from the registered address.
module tb_basket_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_id, cmd_qty;
  logic        cmd_ready, cmd_done, cmd_err;
  logic [2:0]  err_code;
  logic [3:0]  price_addr;
  logic [7:0]  price_data;
  logic [3:0]  num;
  logic [15:0] total;
  logic [2:0]  rd_index;
  logic        rd_valid;
  logic [3:0]  rd_id, rd_qty;

  int pass_chk = 0;
  int total_chk = 0;

  always #10 clk = ~clk;
  always_comb price_data = 8'(10 + 5 * int'(price_addr));

  basket_sequencer dut (
    .CLOCK_50         (clk),
    .RESET            (rst),
    .CMD_Valid        (cmd_valid),
    .CMD_Op           (cmd_op),
    .CMD_ID           (cmd_id),
    .CMD_Qty          (cmd_qty),
    .CMD_Ready        (cmd_ready),
    .CMD_Done         (cmd_done),
    .CMD_Err          (cmd_err),
    .Err_Code         (err_code),
    .Price_Addr       (price_addr),
    .Price_Data       (price_data),
    .BasketProductNum (num),
    .Total            (total),
    .Rd_Index         (rd_index),
    .Rd_Valid         (rd_valid),
    .Rd_ID            (rd_id),
    .Rd_Qty           (rd_qty)
  );

  // Issue one command, return cycles from accept to Done (99 = never) and the
  // error flags seen with Done; returns one cycle after Done.
  task automatic send(input logic [1:0] op, input logic [3:0] id, input logic [3:0] qty,
                      output int lat, output logic err, output logic [2:0] code);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_id = id; cmd_qty = qty;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 99; err = 1'b0; code = 3'd0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (cmd_done === 1'b1) begin
        lat = i; err = cmd_err; code = err_code;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_id = 4'd0; cmd_qty = 4'd0;
    rd_index = 3'd0;
    repeat (2) @(negedge clk);
    total_chk++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", cmd_ready); else pass_chk++;
    total_chk++; if ({cmd_done, cmd_err, err_code} !== 5'b0) $display("FAIL reset_done_err: got %b expected 00000", {cmd_done, cmd_err, err_code}); else pass_chk++;
    total_chk++; if (price_addr !== 4'd0) $display("FAIL reset_addr: got %0d expected 0", price_addr); else pass_chk++;
    total_chk++; if (num !== 4'd0 || total !== 16'd0) $display("FAIL reset_count_total: got %0d/%0d expected 0/0", num, total); else pass_chk++;
    total_chk++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); else pass_chk++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_first();
    int lat; logic err; logic [2:0] code;
    send(2'd0, 4'd3, 4'd2, lat, err, code);
    rd_index = 3'd0; #1;
    total_chk++; if (lat !== 3) $display("FAIL add_latency: got %0d expected 3", lat); else pass_chk++;
    total_chk++; if (err !== 1'b0) $display("FAIL add_err: got %b expected 0", err); else pass_chk++;
    total_chk++; if (num !== 4'd1) $display("FAIL add_count: got %0d expected 1", num); else pass_chk++;
    total_chk++; if (total !== 16'd50) $display("FAIL add_total: got %0d expected 50", total); else pass_chk++;
    total_chk++; if ({rd_valid, rd_id, rd_qty} !== {1'b1, 4'd3, 4'd2}) $display("FAIL add_rd0: got %b/%0d/%0d expected 1/3/2", rd_valid, rd_id, rd_qty); else pass_chk++;
    total_chk++; if (price_addr !== 4'd3) $display("FAIL add_price_addr: got %0d expected 3", price_addr); else pass_chk++;
  endtask

  task automatic test_qty_sat();
    int lat; logic err; logic [2:0] code;
    send(2'd0, 4'd3, 4'd8, lat, err, code);
    rd_index = 3'd0; #1;
    total_chk++; if (err !== 1'b1 || code !== 3'd4) $display("FAIL sat_err: got %b/%0d expected 1/4", err, code); else pass_chk++;
    total_chk++; if (rd_qty !== 4'd9) $display("FAIL sat_qty: got %0d expected 9", rd_qty); else pass_chk++;
    total_chk++; if (total !== 16'd225 || num !== 4'd1) $display("FAIL sat_total: got %0d/%0d expected 225/1", total, num); else pass_chk++;
  endtask

  task automatic test_full();
    int lat; logic err; logic [2:0] code;
    logic [3:0] ids [7];
    ids = '{4'd1, 4'd2, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9};
    foreach (ids[k]) send(2'd0, ids[k], 4'd1, lat, err, code);
    total_chk++; if (num !== 4'd8 || total !== 16'd480) $display("FAIL fill_state: got %0d/%0d expected 8/480", num, total); else pass_chk++;
    rd_index = 3'd7; #1;
    total_chk++; if ({rd_valid, rd_id} !== {1'b1, 4'd9}) $display("FAIL fill_rd7: got %b/%0d expected 1/9", rd_valid, rd_id); else pass_chk++;
    send(2'd0, 4'd10, 4'd1, lat, err, code);
    total_chk++; if (err !== 1'b1 || code !== 3'd1) $display("FAIL full_err: got %b/%0d expected 1/1", err, code); else pass_chk++;
    total_chk++; if (num !== 4'd8 || total !== 16'd480) $display("FAIL full_state: got %0d/%0d expected 8/480", num, total); else pass_chk++;
    send(2'd0, 4'd3, 4'd0, lat, err, code);
    total_chk++; if (err !== 1'b1 || code !== 3'd3 || total !== 16'd480) $display("FAIL zero_qty: got %b/%0d/%0d expected 1/3/480", err, code, total); else pass_chk++;
  endtask

  task automatic test_remove();
    int lat; logic err; logic [2:0] code;
    send(2'd1, 4'd5, 4'd0, lat, err, code);
    total_chk++; if (err !== 1'b1 || code !== 3'd2 || num !== 4'd8) $display("FAIL rm_absent: got %b/%0d/%0d expected 1/2/8", err, code, num); else pass_chk++;
    send(2'd1, 4'd2, 4'd0, lat, err, code);
    rd_index = 3'd2; #1;
    total_chk++; if (err !== 1'b0 || num !== 4'd7 || total !== 16'd460) $display("FAIL rm_hit: got %b/%0d/%0d expected 0/7/460", err, num, total); else pass_chk++;
    total_chk++; if (rd_valid !== 1'b0) $display("FAIL rm_slot2_valid: got %b expected 0", rd_valid); else pass_chk++;
    send(2'd0, 4'd12, 4'd3, lat, err, code);
    #1;
    total_chk++; if ({rd_valid, rd_id, rd_qty} !== {1'b1, 4'd12, 4'd3}) $display("FAIL reuse_slot2: got %b/%0d/%0d expected 1/12/3", rd_valid, rd_id, rd_qty); else pass_chk++;
    total_chk++; if (num !== 4'd8 || total !== 16'd670) $display("FAIL reuse_state: got %0d/%0d expected 8/670", num, total); else pass_chk++;
    send(2'd3, 4'd1, 4'd1, lat, err, code);
    total_chk++; if (lat !== 1 || err !== 1'b1 || code !== 3'd5) $display("FAIL bad_op: got %0d/%b/%0d expected 1/1/5", lat, err, code); else pass_chk++;
    total_chk++; if (num !== 4'd8 || total !== 16'd670) $display("FAIL bad_op_state: got %0d/%0d expected 8/670", num, total); else pass_chk++;
  endtask

  task automatic test_back_to_back();
    int lat; logic err; logic [2:0] code;
    int dones;
    logic ready_mid;
    send(2'd1, 4'd12, 4'd0, lat, err, code);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_id = 4'd13; cmd_qty = 4'd1;
    @(posedge clk);
    #1 cmd_op = 2'd2;
    dones = 0; ready_mid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (cmd_done === 1'b1) dones++;
      if (i == 2) ready_mid = cmd_ready;
      if (i == 3) cmd_valid = 1'b0;
    end
    total_chk++; if (dones !== 1) $display("FAIL b2b_done_count: got %0d expected 1", dones); else pass_chk++;
    total_chk++; if (ready_mid !== 1'b0) $display("FAIL b2b_ready_busy: got %b expected 0", ready_mid); else pass_chk++;
    total_chk++; if (num !== 4'd8 || total !== 16'd535) $display("FAIL b2b_state: got %0d/%0d expected 8/535", num, total); else pass_chk++;
    send(2'd2, 4'd0, 4'd0, lat, err, code);
    rd_index = 3'd0; #1;
    total_chk++; if (lat !== 1 || err !== 1'b0) $display("FAIL clear_done: got %0d/%b expected 1/0", lat, err); else pass_chk++;
    total_chk++; if (num !== 4'd0 || total !== 16'd0 || rd_valid !== 1'b0) $display("FAIL clear_state: got %0d/%0d/%b expected 0/0/0", num, total, rd_valid); else pass_chk++;
  endtask

  task automatic test_reset_mid();
    int lat; logic err; logic [2:0] code;
    int dones;
    send(2'd0, 4'd4, 4'd1, lat, err, code);
    total_chk++; if (total !== 16'd30 || num !== 4'd1) $display("FAIL pre_reset_state: got %0d/%0d expected 30/1", total, num); else pass_chk++;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_id = 4'd3; cmd_qty = 4'd2;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total_chk++; if (price_addr !== 4'd3 || cmd_ready !== 1'b0) $display("FAIL wait_state: got %0d/%b expected 3/0", price_addr, cmd_ready); else pass_chk++;
    rst = 1'b1;
    #1;
    total_chk++; if ({cmd_ready, cmd_done, cmd_err, err_code} !== 6'b100000) $display("FAIL mid_reset_ctrl: got %b expected 100000", {cmd_ready, cmd_done, cmd_err, err_code}); else pass_chk++;
    total_chk++; if (num !== 4'd0 || total !== 16'd0 || price_addr !== 4'd0) $display("FAIL mid_reset_state: got %0d/%0d/%0d expected 0/0/0", num, total, price_addr); else pass_chk++;
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (5) begin
      @(negedge clk);
      if (cmd_done === 1'b1) dones++;
    end
    total_chk++; if (dones !== 0 || cmd_ready !== 1'b1 || total !== 16'd0) $display("FAIL post_reset: got %0d/%b/%0d expected 0/1/0", dones, cmd_ready, total); else pass_chk++;
  endtask

  initial begin
    test_reset();
    test_add_first();
    test_qty_sat();
    test_full();
    test_remove();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_chk, total_chk);
    $finish;
  end

endmodule
